// File: rtl/alu_operand_stage_if.sv
// Operation, write-back and output-buffer signals between decode, the operand
// stage and execute. The stage itself uses the slave view.
interface alu_operand_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [15:0] imm;
  logic [4:0]  shamt;
  logic        a_sel;
  logic [1:0]  b_sel;
  logic [3:0]  aluc_in;

  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  aluc;

  modport master (
    output in_valid, rs_addr, rt_addr, imm, shamt, a_sel, b_sel, aluc_in,
    output wb_en, wb_addr, wb_data,
    output out_ready,
    input  in_ready, out_valid, a, b, aluc
  );

  modport slave (
    input  in_valid, rs_addr, rt_addr, imm, shamt, a_sel, b_sel, aluc_in,
    input  wb_en, wb_addr, wb_data,
    input  out_ready,
    output in_ready, out_valid, a, b, aluc
  );
endinterface

// File: rtl/alu_operand_stage.sv
// Operand-fetch stage: 32x32 register file with write-first bypass, operand
// muxing, and a one-entry valid/ready output buffer toward the ALU.
//
// state    | meaning
// ST_EMPTY | output buffer holds no operation (out_valid = 0)
// ST_FULL  | a/b/aluc hold an operation awaiting out_ready
module alu_operand_stage #(
  parameter int DATA_W = 32,
  parameter int REG_N  = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  alu_operand_stage_if.slave op_if
);

  localparam int AW = 5;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] rf_q [REG_N];
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [3:0]        aluc_q, aluc_d;

  logic              wr_en;
  logic              in_ready;
  logic              accept;
  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] rt_val;
  logic [DATA_W-1:0] opnd_a;
  logic [DATA_W-1:0] opnd_b;

  assign wr_en    = op_if.wb_en && (op_if.wb_addr != '0);
  assign in_ready = !rst_i && ((state_q == ST_EMPTY) || op_if.out_ready);
  assign accept   = op_if.in_valid && in_ready;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < REG_N; i++) begin
        rf_q[i] <= '0;
      end
    end else if (wr_en) begin
      rf_q[op_if.wb_addr] <= op_if.wb_data;
    end
  end

  // Address 0 reads zero and never takes the bypass; otherwise write-first.
  always_comb begin
    rs_val = '0;
    if (op_if.rs_addr != '0) begin
      if (wr_en && (op_if.wb_addr == op_if.rs_addr)) begin
        rs_val = op_if.wb_data;
      end else begin
        rs_val = rf_q[op_if.rs_addr];
      end
    end
  end

  always_comb begin
    rt_val = '0;
    if (op_if.rt_addr != '0) begin
      if (wr_en && (op_if.wb_addr == op_if.rt_addr)) begin
        rt_val = op_if.wb_data;
      end else begin
        rt_val = rf_q[op_if.rt_addr];
      end
    end
  end

  always_comb begin
    opnd_a = op_if.a_sel ? {{(DATA_W-AW){1'b0}}, op_if.shamt} : rs_val;
    opnd_b = '0;
    case (op_if.b_sel)
      2'b00:   opnd_b = rt_val;
      2'b01:   opnd_b = {{(DATA_W-16){op_if.imm[15]}}, op_if.imm};
      2'b10:   opnd_b = {{(DATA_W-16){1'b0}}, op_if.imm};
      default: opnd_b = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    aluc_d  = aluc_q;
    if (accept) begin
      a_d    = opnd_a;
      b_d    = opnd_b;
      aluc_d = op_if.aluc_in;
    end
    case (state_q)
      ST_EMPTY: begin
        if (accept) state_d = ST_FULL;
      end
      ST_FULL: begin
        if (op_if.out_ready && !accept) state_d = ST_EMPTY;
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_EMPTY;
      a_q     <= '0;
      b_q     <= '0;
      aluc_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      aluc_q  <= aluc_d;
    end
  end

  assign op_if.in_ready  = in_ready;
  assign op_if.out_valid = (state_q == ST_FULL);
  assign op_if.a         = a_q;
  assign op_if.b         = b_q;
  assign op_if.aluc      = aluc_q;

endmodule
